fxp8s_mat_streamer: RTL and testbench

FXP8S_MAT_STREAMER -- requirements
Module: fxp8s_mat_streamer

---
 rtl/fxp8s_mat_streamer.sv | 245 ++++++++++++++++++++++++
 tb/tb_fxp8s_mat_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp8s_mat_streamer.sv
// -----------------------------------------------------------------------------
// fxp8s_mat_streamer
//
// Streams two small signed fixed-point matrices (A, then B) from an internal
// load buffer toward a systolic array. It then collects the 3x3 result matrix
// C from the array into a result buffer that the host can read back.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ld_we/ld_addr/ld_data    host writes into the load buffer (A at 0-8,
//                            B at 9-17), honoured only while not busy
//   cfg_{a,b}_{rows,cols}    active matrix dimensions 1..3 (0 means 3),
//                            latched when start is accepted
//   start                    begin a stream/collect sequence (IDLE/DONE only)
//   busy, done               sequence in progress / sticky completion flag
//   tx_en/tx_rdy             valid/ready toward the array input
//   tx_mat                   0 = word from A, 1 = word from B
//   tx_new_row               last word of a short row (receiver pads the row)
//   tx_mat_done              last word of a short matrix (receiver pads it)
//   tx_data                  stream word
//   rx_en/rx_rdy/rx_data     valid/ready/data from the array output, row-major
//   res_addr/res_data        combinational read of the result buffer
// -----------------------------------------------------------------------------
module fxp8s_mat_streamer #(
  parameter int W   = 8,
  parameter int DIM = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_we,
  input  logic [4:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic [1:0]   cfg_a_rows,
  input  logic [1:0]   cfg_a_cols,
  input  logic [1:0]   cfg_b_rows,
  input  logic [1:0]   cfg_b_cols,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         tx_en,
  input  logic         tx_rdy,
  output logic         tx_mat,
  output logic         tx_new_row,
  output logic         tx_mat_done,
  output logic [W-1:0] tx_data,
  input  logic         rx_en,
  output logic         rx_rdy,
  input  logic [W-1:0] rx_data,
  input  logic [3:0]   res_addr,
  output logic [W-1:0] res_data
);

  localparam int NE = DIM * DIM;   // words per matrix
  localparam int NL = 2 * NE;      // load buffer holds A and B

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    RECV,
    DONE
  } state_t;

  state_t       state_reg;
  logic [W-1:0] ld_mem  [0:NL-1];
  logic [W-1:0] res_mem [0:NE-1];

  logic [1:0]   a_rows_reg, a_cols_reg, b_rows_reg, b_cols_reg;
  logic [1:0]   r_reg, c_reg;       // index of the word currently on tx_data
  logic [3:0]   cnt_reg;            // result capture index

  // A dimension of 0 selects the full size.
  function automatic logic [1:0] dim_eff(input logic [1:0] v);
    return (v == 2'd0) ? 2'(DIM) : v;
  endfunction

  // Returns {new_row, mat_done} for word (r,c) of an nr x nc matrix.
  function automatic logic [1:0] word_flags(input logic [1:0] r, input logic [1:0] c,
                                            input logic [1:0] nr, input logic [1:0] nc);
    logic last_w;
    logic end_row;
    end_row = (c == nc - 2'd1);
    last_w  = (r == nr - 2'd1) && end_row;
    return {(!last_w && end_row && (nc < 2'(DIM))),
            (last_w && ((nr < 2'(DIM)) || (nc < 2'(DIM))))};
  endfunction

  // Load buffer address of word (r,c); the stride is always DIM so short
  // matrices simply leave their inactive entries unread.
  function automatic logic [4:0] word_addr(input logic mat, input logic [1:0] r,
                                           input logic [1:0] c);
    return (mat ? 5'(NE) : 5'd0) + ({3'b000, r} * 5'(DIM)) + {3'b000, c};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-word selection. The word presented after a transfer (or at start) is
  // precomputed here so the tx registers can be reloaded in the same cycle,
  // which is what gives one word per cycle with no bubble between A and B.
  // ---------------------------------------------------------------------------
  logic         start_acc;
  logic [1:0]   cur_rows, cur_cols;
  logic         last_word;
  logic         sel_mat;
  logic [1:0]   sel_r, sel_c, sel_rows, sel_cols;
  logic [1:0]   sel_flags;
  logic [4:0]   sel_addr;
  logic [W-1:0] sel_data;

  always_comb begin
    start_acc = start && ((state_reg == IDLE) || (state_reg == DONE));
    cur_rows  = (state_reg == SEND_B) ? b_rows_reg : a_rows_reg;
    cur_cols  = (state_reg == SEND_B) ? b_cols_reg : a_cols_reg;
    last_word = (r_reg == cur_rows - 2'd1) && (c_reg == cur_cols - 2'd1);

    sel_mat  = (state_reg == SEND_B);
    sel_r    = r_reg;
    sel_c    = c_reg + 2'd1;
    sel_rows = cur_rows;
    sel_cols = cur_cols;

    if (start_acc) begin
      // First word of A uses the dimensions being latched this cycle.
      sel_mat  = 1'b0;
      sel_r    = 2'd0;
      sel_c    = 2'd0;
      sel_rows = dim_eff(cfg_a_rows);
      sel_cols = dim_eff(cfg_a_cols);
    end else if (last_word) begin
      // End of A rolls straight into B[0][0]; end of B is not used.
      sel_mat  = 1'b1;
      sel_r    = 2'd0;
      sel_c    = 2'd0;
      sel_rows = b_rows_reg;
      sel_cols = b_cols_reg;
    end else if (c_reg == cur_cols - 2'd1) begin
      sel_r = r_reg + 2'd1;
      sel_c = 2'd0;
    end

    sel_flags = word_flags(sel_r, sel_c, sel_rows, sel_cols);
    sel_addr  = word_addr(sel_mat, sel_r, sel_c);
    sel_data  = ld_mem[sel_addr];
  end

  // Result read-back; addresses past the matrix read as zero.
  always_comb begin
    res_data = '0;
    if (res_addr < 4'(NE)) begin
      res_data = res_mem[res_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_en       <= 1'b0;
      tx_mat      <= 1'b0;
      tx_new_row  <= 1'b0;
      tx_mat_done <= 1'b0;
      tx_data     <= '0;
      rx_rdy      <= 1'b0;
      a_rows_reg  <= 2'(DIM);
      a_cols_reg  <= 2'(DIM);
      b_rows_reg  <= 2'(DIM);
      b_cols_reg  <= 2'(DIM);
      r_reg       <= 2'd0;
      c_reg       <= 2'd0;
      cnt_reg     <= 4'd0;
      for (int i = 0; i < NL; i++) ld_mem[i] <= '0;
      for (int i = 0; i < NE; i++) res_mem[i] <= '0;
    end else begin
      if (ld_we && !busy && (ld_addr < 5'(NL))) begin
        ld_mem[ld_addr] <= ld_data;
      end

      case (state_reg)
        IDLE, DONE: begin
          if (start_acc) begin
            a_rows_reg  <= dim_eff(cfg_a_rows);
            a_cols_reg  <= dim_eff(cfg_a_cols);
            b_rows_reg  <= dim_eff(cfg_b_rows);
            b_cols_reg  <= dim_eff(cfg_b_cols);
            done        <= 1'b0;
            busy        <= 1'b1;
            cnt_reg     <= 4'd0;
            for (int i = 0; i < NE; i++) res_mem[i] <= '0;
            state_reg   <= SEND_A;
            tx_en       <= 1'b1;
            tx_mat      <= sel_mat;
            tx_new_row  <= sel_flags[1];
            tx_mat_done <= sel_flags[0];
            tx_data     <= sel_data;
            r_reg       <= sel_r;
            c_reg       <= sel_c;
          end
        end

        SEND_A, SEND_B: begin
          if (tx_rdy) begin
            if ((state_reg == SEND_B) && last_word) begin
              state_reg   <= RECV;
              tx_en       <= 1'b0;
              tx_mat      <= 1'b0;
              tx_new_row  <= 1'b0;
              tx_mat_done <= 1'b0;
              tx_data     <= '0;
              rx_rdy      <= 1'b1;
            end else begin
              if (last_word) begin
                state_reg <= SEND_B;
              end
              tx_mat      <= sel_mat;
              tx_new_row  <= sel_flags[1];
              tx_mat_done <= sel_flags[0];
              tx_data     <= sel_data;
              r_reg       <= sel_r;
              c_reg       <= sel_c;
            end
          end
        end

        RECV: begin
          if (rx_en) begin
            res_mem[cnt_reg] <= rx_data;
            cnt_reg          <= cnt_reg + 4'd1;
            if (cnt_reg == 4'(NE - 1)) begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              rx_rdy    <= 1'b0;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp8s_mat_streamer.sv
// Directed bench: loads matrices, runs stream/collect sequences and compares
// every transferred word, flag and read-back result with hand-derived values.
module tb_fxp8s_mat_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_we = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [1:0] cfg_a_rows = '0, cfg_a_cols = '0, cfg_b_rows = '0, cfg_b_cols = '0;
  logic       start = 1'b0;
  logic       busy, done, tx_en, tx_mat, tx_new_row, tx_mat_done, rx_rdy;
  logic       tx_rdy = 1'b0;
  logic [7:0] tx_data;
  logic       rx_en = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] res_addr = '0;
  logic [7:0] res_data;

  int passed = 0;
  int total  = 0;

  logic [10:0] tx_q [$];   // {mat, new_row, mat_done, data}
  int          tx_cyc [$];
  logic [10:0] exp_q [$];
  int          rx_cnt = 0;
  int          cyc = 0;
  int          hold_err = 0;
  bit          hold_pend = 1'b0;
  logic [10:0] hold_word = '0;

  fxp8s_mat_streamer #(.W(8), .DIM(3)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_a_rows(cfg_a_rows), .cfg_a_cols(cfg_a_cols),
    .cfg_b_rows(cfg_b_rows), .cfg_b_cols(cfg_b_cols),
    .start(start), .busy(busy), .done(done),
    .tx_en(tx_en), .tx_rdy(tx_rdy), .tx_mat(tx_mat), .tx_new_row(tx_new_row),
    .tx_mat_done(tx_mat_done), .tx_data(tx_data),
    .rx_en(rx_en), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .res_addr(res_addr), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [10:0] cur;
    cur = {tx_mat, tx_new_row, tx_mat_done, tx_data};
    if (hold_pend && !rst && (cur !== hold_word)) hold_err++;
    hold_pend = tx_en && !tx_rdy && !rst;
    hold_word = cur;
    if (!rst && tx_en && tx_rdy) begin
      tx_q.push_back(cur);
      tx_cyc.push_back(cyc);
      $display("tx  mat=%0d new_row=%0d mat_done=%0d data=%02h", tx_mat, tx_new_row,
               tx_mat_done, tx_data);
    end
    if (!rst && rx_en && rx_rdy) begin
      rx_cnt++;
      $display("rx  data=%02h", rx_data);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [10:0] w(input bit m, input bit nr, input bit md, input logic [7:0] d);
    return {m, nr, md, d};
  endfunction

  task automatic load_all(input logic [7:0] a_base, input logic [7:0] b_base);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      ld_we   = 1'b1;
      ld_addr = 5'(i);
      ld_data = (i < 9) ? a_base + 8'(i) : b_base + 8'(i - 9);
    end
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic run(input bit toggle, input bit gap, input bit poke, input int abort_at);
    int gap_left;
    gap_left = gap ? 3 : 0;
    tx_q.delete();
    tx_cyc.delete();
    rx_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; tx_rdy = 1'b1; rx_en = 1'b1; rx_data = 8'h20;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_tx_en", tx_en, 1);
    chk("start_done_clr", done, 0);
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      if (abort_at > 0 && tx_q.size() >= abort_at) break;
      tx_rdy = toggle ? ~tx_rdy : 1'b1;
      if (rx_cnt == 4 && gap_left > 0) begin
        rx_en = 1'b0;
        gap_left--;
      end else begin
        rx_en = 1'b1;
      end
      rx_data = 8'h20 + 8'(rx_cnt);
      start   = poke && (k == 3);
      ld_we   = poke && (k == 3);
      ld_addr = 5'd0;
      ld_data = 8'hEE;
      @(posedge clk); #1;
    end
    start = 1'b0; ld_we = 1'b0; rx_en = 1'b0; tx_rdy = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), tx_q[i], exp_q[i]);
    end
  endtask

  task automatic cmp_results(input string tag);
    for (int i = 0; i < 9; i++) begin
      res_addr = 4'(i); #1;
      chk($sformatf("%s_res%0d", tag, i), res_data, 8'h20 + 8'(i));
    end
  endtask

  task automatic full_expect(input logic [7:0] a_base, input logic [7:0] b_base);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(w(0, 0, 0, a_base + 8'(i)));
    for (int i = 0; i < 9; i++) exp_q.push_back(w(1, 0, 0, b_base + 8'(i)));
  endtask

  initial begin
    logic [7:0] acc;

    // Reset, with start asserted alongside it.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1; start = 1'b0; rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_flags", {tx_mat, tx_new_row, tx_mat_done}, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_rdy", rx_rdy, 0);

    // Full 3x3: cfg_a uses 0 (means 3), cfg_b explicit 3.
    load_all(8'd1, 8'd10);
    cfg_a_rows = 2'd0; cfg_a_cols = 2'd0; cfg_b_rows = 2'd3; cfg_b_cols = 2'd3;
    run(0, 0, 0, 0);
    full_expect(8'd1, 8'd10);
    cmp_stream("full");
    chk("full_span", tx_cyc[17] - tx_cyc[0], 17);
    chk("full_rx_cnt", rx_cnt, 9);
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    chk("full_tx_en_off", tx_en, 0);
    cmp_results("full");
    res_addr = 4'd9;  #1; chk("res_addr9", res_data, 0);
    res_addr = 4'd15; #1; chk("res_addr15", res_data, 0);

    // Short A 2x2, full B.
    cfg_a_rows = 2'd2; cfg_a_cols = 2'd2; cfg_b_rows = 2'd3; cfg_b_cols = 2'd3;
    run(0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(w(0, 0, 0, 8'd1));
    exp_q.push_back(w(0, 1, 0, 8'd2));
    exp_q.push_back(w(0, 0, 0, 8'd4));
    exp_q.push_back(w(0, 0, 1, 8'd5));
    for (int i = 0; i < 9; i++) exp_q.push_back(w(1, 0, 0, 8'd10 + 8'(i)));
    cmp_stream("a2x2");
    chk("a2x2_done", done, 1);

    // Full A, B 3x2, with start/ld_we poked while busy.
    cfg_a_rows = 2'd3; cfg_a_cols = 2'd3; cfg_b_rows = 2'd3; cfg_b_cols = 2'd2;
    run(0, 0, 1, 0);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(w(0, 0, 0, 8'd1 + 8'(i)));
    exp_q.push_back(w(1, 0, 0, 8'd10));
    exp_q.push_back(w(1, 1, 0, 8'd11));
    exp_q.push_back(w(1, 0, 0, 8'd13));
    exp_q.push_back(w(1, 1, 0, 8'd14));
    exp_q.push_back(w(1, 0, 0, 8'd16));
    exp_q.push_back(w(1, 0, 1, 8'd17));
    cmp_stream("b3x2");
    chk("b3x2_done", done, 1);

    // Backpressure on both streams; A00 must still be 1 (poke dropped).
    cfg_b_cols = 2'd3;
    hold_err = 0;
    run(1, 1, 0, 0);
    full_expect(8'd1, 8'd10);
    cmp_stream("bp");
    chk("bp_rx_cnt", rx_cnt, 9);
    chk("bp_hold", hold_err, 0);
    chk("bp_done", done, 1);
    cmp_results("bp");

    // Reset in the middle of SEND_B after 12 transfers.
    run(0, 0, 0, 12);
    chk("mid_in_send_b", tx_mat, 1);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_rdy", rx_rdy, 0);
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      res_addr = 4'(i); #1;
      acc = acc | res_data;
    end
    chk("mid_rst_res_zero", acc, 0);

    // Fresh load and restart from A00.
    load_all(8'h31, 8'h51);
    run(0, 0, 0, 0);
    full_expect(8'h31, 8'h51);
    cmp_stream("fresh");
    chk("fresh_done", done, 1);
    cmp_results("fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
